// File: rtl/utlb_pkg.sv
// Shared types and constants for the utlb_xlate micro-TLB and its CAM.
package utlb_pkg;

   typedef enum logic [1:0] {
      CHECK = 2'd0,
      QUERY = 2'd1,
      RESP  = 2'd2
   } utlb_state_t;

   // Top two address bits that select the unmapped kseg0/kseg1 window.
   localparam logic [1:0] KSEG01_TAG = 2'b10;

   // Per-entry status; vpn/ppn are held in parallel arrays sized by the instance.
   typedef struct packed {
      logic valid;
      logic miss;
      logic invalid;
      logic dirty;
   } utlb_entry_t;

   function automatic int vpn_width(input int addr_w, input int page_bits);
      return addr_w - page_bits;
   endfunction

endpackage

// File: rtl/utlb_cam.sv
// Fully associative vpn compare across all micro-TLB entries; purely combinational.
module utlb_cam
   import utlb_pkg::*;
#(
   parameter int ENTRIES = 4,
   parameter int VPN_W   = 20
) (
   input  utlb_entry_t [ENTRIES-1:0]            entry_i,
   input  logic        [ENTRIES-1:0][VPN_W-1:0] vpn_i,
   input  logic        [ENTRIES-1:0][VPN_W-1:0] ppn_i,
   input  logic                     [VPN_W-1:0] lookup_vpn_i,
   output logic        [ENTRIES-1:0]            hit_vec_o,
   output utlb_entry_t                          hit_entry_o,
   output logic                     [VPN_W-1:0] hit_ppn_o
);

   // Entries are never duplicated, so an OR-reduction mux is sufficient.
   always_comb begin
      hit_vec_o   = '0;
      hit_entry_o = '0;
      hit_ppn_o   = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         hit_vec_o[i] = entry_i[i].valid && (vpn_i[i] == lookup_vpn_i);
         if (hit_vec_o[i]) begin
            hit_entry_o = hit_entry_o | entry_i[i];
            hit_ppn_o   = hit_ppn_o | ppn_i[i];
         end
      end
   end

endmodule

// File: rtl/utlb_xlate.sv
// Data-side micro-TLB: zero-cycle hit/kseg bypass, 2-cycle main-TLB query on miss.
// Optional UTLB_NEG_CACHE_EN also caches miss/invalid results.
module utlb_xlate
   import utlb_pkg::*;
#(
   parameter int ENTRIES   = 4,
   parameter int ADDR_W    = 32,
   parameter int PAGE_BITS = 12
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              req_valid_i,
   input  logic              req_wr_i,
   input  logic [ADDR_W-1:0] req_vaddr_i,
   input  logic              rsp_done_i,
   input  logic              flush_i,
   output logic              rsp_ready_o,
   output logic [ADDR_W-1:0] rsp_paddr_o,
   output logic              rsp_refill_o,
   output logic              rsp_tlbl_o,
   output logic              rsp_tlbs_o,
   output logic              rsp_mod_o,
   output logic [ADDR_W-1:0] tlb_vaddr_o,
   input  logic [ADDR_W-1:0] tlb_paddr_i,
   input  logic              tlb_miss_i,
   input  logic              tlb_invalid_i,
   input  logic              tlb_dirty_i
);

   localparam int VPN_W = vpn_width(ADDR_W, PAGE_BITS);
   localparam int RR_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   utlb_state_t                          state_q, state_d;
   utlb_entry_t [ENTRIES-1:0]            entry_q;
   logic        [ENTRIES-1:0][VPN_W-1:0] vpn_q, ppn_q;
   logic        [RR_W-1:0]               rr_q, rr_d;
   logic        [ADDR_W-1:0]             tlb_vaddr_q, tlb_vaddr_d;
   logic        [VPN_W-1:0]              resp_ppn_q, resp_ppn_d;
   logic resp_miss_q, resp_miss_d, resp_inv_q, resp_inv_d, resp_dirty_q, resp_dirty_d;
   logic alloc, cacheable;

   logic [ENTRIES-1:0] hit_vec;
   utlb_entry_t        hit_entry;
   logic [VPN_W-1:0]   hit_ppn;
   logic               cam_hit, bypass;
   logic               flag_en, f_miss, f_inv, f_dirty;
   logic [VPN_W-1:0]   lookup_vpn;
   logic               unused_ok;

   assign lookup_vpn = req_vaddr_i[ADDR_W-1:PAGE_BITS];
   assign bypass     = (req_vaddr_i[ADDR_W-1 -: 2] == KSEG01_TAG);
   assign cam_hit    = |hit_vec;
   assign unused_ok  = ^{hit_entry.valid, tlb_paddr_i[PAGE_BITS-1:0]};

   utlb_cam #(
      .ENTRIES (ENTRIES),
      .VPN_W   (VPN_W)
   ) u_cam (
      .entry_i      (entry_q),
      .vpn_i        (vpn_q),
      .ppn_i        (ppn_q),
      .lookup_vpn_i (lookup_vpn),
      .hit_vec_o    (hit_vec),
      .hit_entry_o  (hit_entry),
      .hit_ppn_o    (hit_ppn)
   );

`ifdef UTLB_NEG_CACHE_EN
   assign cacheable = 1'b1;
`else
   assign cacheable = !tlb_miss_i && !tlb_invalid_i;
`endif

   always_comb begin
      state_d      = state_q;
      rr_d         = rr_q;
      tlb_vaddr_d  = tlb_vaddr_q;
      resp_ppn_d   = resp_ppn_q;
      resp_miss_d  = resp_miss_q;
      resp_inv_d   = resp_inv_q;
      resp_dirty_d = resp_dirty_q;
      alloc        = 1'b0;
      rsp_ready_o  = 1'b0;
      rsp_paddr_o  = '0;
      flag_en      = 1'b0;
      f_miss       = 1'b0;
      f_inv        = 1'b0;
      f_dirty      = 1'b0;
      case (state_q)
         CHECK: begin
            if (req_valid_i) begin
               if (bypass) begin
                  rsp_ready_o = 1'b1;
                  rsp_paddr_o = req_vaddr_i;
               end else if (cam_hit) begin
                  rsp_ready_o = 1'b1;
                  rsp_paddr_o = {hit_ppn, req_vaddr_i[PAGE_BITS-1:0]};
                  flag_en     = 1'b1;
                  f_miss      = hit_entry.miss;
                  f_inv       = hit_entry.invalid;
                  f_dirty     = hit_entry.dirty;
               end else begin
                  tlb_vaddr_d = req_vaddr_i;
                  state_d     = QUERY;
               end
            end
         end
         QUERY: begin
            resp_ppn_d   = tlb_paddr_i[ADDR_W-1:PAGE_BITS];
            resp_miss_d  = tlb_miss_i;
            resp_inv_d   = tlb_invalid_i;
            resp_dirty_d = tlb_dirty_i;
            alloc        = !flush_i && cacheable;
            if (alloc) begin
               rr_d = (rr_q == RR_W'(ENTRIES - 1)) ? '0 : rr_q + 1'b1;
            end
            state_d = RESP;
         end
         RESP: begin
            if (req_valid_i) begin
               rsp_ready_o = 1'b1;
               rsp_paddr_o = {resp_ppn_q, tlb_vaddr_q[PAGE_BITS-1:0]};
               flag_en     = 1'b1;
               f_miss      = resp_miss_q;
               f_inv       = resp_inv_q;
               f_dirty     = resp_dirty_q;
            end
            if (rsp_done_i || !req_valid_i) begin
               state_d = CHECK;
            end
         end
         default: state_d = CHECK;
      endcase
   end

   // Write type is applied at match time, never stored in the entry.
   assign rsp_tlbl_o   = flag_en && !req_wr_i && (f_miss || f_inv);
   assign rsp_tlbs_o   = flag_en && req_wr_i && (f_miss || f_inv);
   assign rsp_mod_o    = flag_en && req_wr_i && !f_miss && !f_inv && !f_dirty;
   assign rsp_refill_o = f_miss && (rsp_tlbl_o || rsp_tlbs_o);
   assign tlb_vaddr_o  = tlb_vaddr_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= CHECK;
         entry_q      <= '0;
         vpn_q        <= '0;
         ppn_q        <= '0;
         rr_q         <= '0;
         tlb_vaddr_q  <= '0;
         resp_ppn_q   <= '0;
         resp_miss_q  <= 1'b0;
         resp_inv_q   <= 1'b0;
         resp_dirty_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         tlb_vaddr_q  <= tlb_vaddr_d;
         resp_ppn_q   <= resp_ppn_d;
         resp_miss_q  <= resp_miss_d;
         resp_inv_q   <= resp_inv_d;
         resp_dirty_q <= resp_dirty_d;
         if (flush_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
               entry_q[i].valid <= 1'b0;
            end
         end else if (alloc) begin
            entry_q[rr_q] <= utlb_entry_t'{valid: 1'b1, miss: tlb_miss_i,
                                           invalid: tlb_invalid_i, dirty: tlb_dirty_i};
            vpn_q[rr_q]   <= tlb_vaddr_q[ADDR_W-1:PAGE_BITS];
            ppn_q[rr_q]   <= tlb_paddr_i[ADDR_W-1:PAGE_BITS];
         end
      end
   end

endmodule

// File: tb/tb_utlb_xlate.sv
// Directed self-checking bench for utlb_xlate (ENTRIES=4, ADDR_W=32, PAGE_BITS=12).
module tb_utlb_xlate;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid, req_wr, rsp_done, flush;
   logic [31:0] req_vaddr;
   logic        rsp_ready, rsp_refill, rsp_tlbl, rsp_tlbs, rsp_mod;
   logic [31:0] rsp_paddr, tlb_vaddr, tlb_paddr;
   logic        tlb_miss, tlb_invalid, tlb_dirty;

   int checks = 0;
   int errors = 0;

   int          lat;
   logic [31:0] pa;
   logic [3:0]  fl;

   always #5 clk = ~clk;

   utlb_xlate #(.ENTRIES(4), .ADDR_W(32), .PAGE_BITS(12)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .req_valid_i   (req_valid),
      .req_wr_i      (req_wr),
      .req_vaddr_i   (req_vaddr),
      .rsp_done_i    (rsp_done),
      .flush_i       (flush),
      .rsp_ready_o   (rsp_ready),
      .rsp_paddr_o   (rsp_paddr),
      .rsp_refill_o  (rsp_refill),
      .rsp_tlbl_o    (rsp_tlbl),
      .rsp_tlbs_o    (rsp_tlbs),
      .rsp_mod_o     (rsp_mod),
      .tlb_vaddr_o   (tlb_vaddr),
      .tlb_paddr_i   (tlb_paddr),
      .tlb_miss_i    (tlb_miss),
      .tlb_invalid_i (tlb_invalid),
      .tlb_dirty_i   (tlb_dirty)
   );

   task automatic set_tlb(input logic [31:0] p, input logic m, input logic i, input logic d);
      tlb_paddr = p; tlb_miss = m; tlb_invalid = i; tlb_dirty = d;
   endtask

   // Called at posedge+1 in CHECK; returns at posedge+1 after the response was accepted.
   // lat = cycles until rsp_ready (-1 if it never came), fl = {refill, tlbl, tlbs, mod}.
   task automatic access(input logic [31:0] va, input logic wr);
      req_valid = 1'b1; req_wr = wr; req_vaddr = va; lat = -1; pa = '0; fl = '0;
      for (int c = 0; c < 10; c++) begin
         #3;
         if (rsp_ready) begin
            lat = c; pa = rsp_paddr; fl = {rsp_refill, rsp_tlbl, rsp_tlbs, rsp_mod};
            rsp_done = 1'b1;
         end
         @(posedge clk); #1;
         if (lat >= 0) break;
      end
      rsp_done = 1'b0; req_valid = 1'b0; req_wr = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0; req_valid = 1'b0; rsp_done = 1'b0; flush = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      resetn = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_vaddr = 32'h0040_0000;
      rsp_done = 1'b0; flush = 1'b0; set_tlb(32'h0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); @(posedge clk); #4;
      checks++; if (rsp_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", rsp_ready); end
      checks++; if (rsp_paddr !== 32'h0) begin errors++; $display("FAIL reset_paddr got %h exp 0", rsp_paddr); end
      checks++; if ({rsp_refill, rsp_tlbl, rsp_tlbs, rsp_mod} !== 4'b0) begin errors++;
         $display("FAIL reset_flags got %b exp 0000", {rsp_refill, rsp_tlbl, rsp_tlbs, rsp_mod}); end
      checks++; if (tlb_vaddr !== 32'h0) begin errors++; $display("FAIL reset_tlb_vaddr got %h exp 0", tlb_vaddr); end
      @(posedge clk); #1;
      resetn = 1'b1;
   endtask

   task automatic test_bypass();
      access(32'h8000_1000, 1'b0);
      checks++; if (lat !== 0) begin errors++; $display("FAIL bypass_lat got %0d exp 0", lat); end
      checks++; if (pa !== 32'h8000_1000) begin errors++; $display("FAIL bypass_paddr got %h exp 80001000", pa); end
      checks++; if (fl !== 4'b0) begin errors++; $display("FAIL bypass_flags got %b exp 0000", fl); end
      checks++; if (tlb_vaddr !== 32'h0) begin errors++; $display("FAIL bypass_tlb_vaddr got %h exp 0", tlb_vaddr); end
      access(32'hA000_0044, 1'b1);
      checks++; if (lat !== 0 || pa !== 32'hA000_0044 || fl !== 4'b0) begin errors++;
         $display("FAIL bypass_kseg1_store got lat %0d pa %h fl %b exp 0 a0000044 0000", lat, pa, fl); end
   endtask

   task automatic test_miss_hit();
      set_tlb(32'h0123_4000, 1'b0, 1'b0, 1'b1);
      access(32'h0040_0010, 1'b0);
      checks++; if (lat !== 2) begin errors++; $display("FAIL miss_lat got %0d exp 2", lat); end
      checks++; if (pa !== 32'h0123_4010) begin errors++; $display("FAIL miss_paddr got %h exp 01234010", pa); end
      checks++; if (tlb_vaddr !== 32'h0040_0010) begin errors++; $display("FAIL miss_tlb_vaddr got %h exp 00400010", tlb_vaddr); end
      set_tlb(32'hDEAD_0000, 1'b1, 1'b1, 1'b0);
      access(32'h0040_0020, 1'b0);
      checks++; if (lat !== 0 || pa !== 32'h0123_4020 || fl !== 4'b0) begin errors++;
         $display("FAIL hit_load got lat %0d pa %h fl %b exp 0 01234020 0000", lat, pa, fl); end
      access(32'h0040_0ffc, 1'b1);
      checks++; if (lat !== 0 || pa !== 32'h0123_4ffc || fl !== 4'b0) begin errors++;
         $display("FAIL hit_store_dirty got lat %0d pa %h fl %b exp 0 01234ffc 0000", lat, pa, fl); end
   endtask

   task automatic test_replace();
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         set_tlb(32'h0010_0000 + i * 32'h1000, 1'b0, 1'b0, 1'b1);
         access(i * 32'h1000 + 32'h4, 1'b0);
         checks++; if (lat !== 2 || pa !== 32'h0010_0004 + i * 32'h1000) begin errors++;
            $display("FAIL replace_fill_%0d got lat %0d pa %h exp 2 %h", i, lat, pa, 32'h0010_0004 + i * 32'h1000); end
      end
      set_tlb(32'hDEAD_0000, 1'b0, 1'b0, 1'b1);
      for (int i = 2; i <= 5; i++) begin
         access(i * 32'h1000 + 32'h8, 1'b0);
         checks++; if (lat !== 0 || pa !== 32'h0010_0008 + i * 32'h1000) begin errors++;
            $display("FAIL replace_hit_%0d got lat %0d pa %h exp 0 %h", i, lat, pa, 32'h0010_0008 + i * 32'h1000); end
      end
      access(32'h0000_1008, 1'b0);
      checks++; if (lat !== 2 || pa !== 32'hDEAD_0008) begin errors++;
         $display("FAIL replace_evicted got lat %0d pa %h exp 2 dead0008", lat, pa); end
   endtask

   task automatic test_exceptions();
      do_reset();
      set_tlb(32'h0222_2000, 1'b0, 1'b0, 1'b0);
      access(32'h0000_7008, 1'b1);
      checks++; if (lat !== 2 || fl !== 4'b0001 || pa !== 32'h0222_2008) begin errors++;
         $display("FAIL exc_mod_miss got lat %0d fl %b pa %h exp 2 0001 02222008", lat, fl, pa); end
      access(32'h0000_700c, 1'b0);
      checks++; if (lat !== 0 || fl !== 4'b0000) begin errors++;
         $display("FAIL exc_clean_load_hit got lat %0d fl %b exp 0 0000", lat, fl); end
      access(32'h0000_7010, 1'b1);
      checks++; if (lat !== 0 || fl !== 4'b0001) begin errors++;
         $display("FAIL exc_mod_hit got lat %0d fl %b exp 0 0001", lat, fl); end
      set_tlb(32'h0444_4000, 1'b1, 1'b0, 1'b0);
      access(32'h0000_9000, 1'b0);
      checks++; if (lat !== 2 || fl !== 4'b1100) begin errors++;
         $display("FAIL exc_tlbl_refill got lat %0d fl %b exp 2 1100", lat, fl); end
      access(32'h0000_9004, 1'b0);
`ifdef UTLB_NEG_CACHE_EN
      checks++; if (lat !== 0 || fl !== 4'b1100) begin errors++;
         $display("FAIL exc_tlbl_repeat got lat %0d fl %b exp 0 1100", lat, fl); end
`else
      checks++; if (lat !== 2 || fl !== 4'b1100) begin errors++;
         $display("FAIL exc_tlbl_repeat got lat %0d fl %b exp 2 1100", lat, fl); end
`endif
      set_tlb(32'h0555_5000, 1'b0, 1'b1, 1'b1);
      access(32'h0000_A000, 1'b1);
      checks++; if (lat !== 2 || fl !== 4'b0010) begin errors++;
         $display("FAIL exc_tlbs_invalid got lat %0d fl %b exp 2 0010", lat, fl); end
   endtask

   task automatic test_flush();
      do_reset();
      set_tlb(32'h0333_3000, 1'b0, 1'b0, 1'b1);
      req_valid = 1'b1; req_wr = 1'b0; req_vaddr = 32'h0000_B004;
      #3;
      checks++; if (rsp_ready !== 1'b0) begin errors++; $display("FAIL flushq_cycle0 got %b exp 0", rsp_ready); end
      @(posedge clk); #1;
      flush = 1'b1;
      #3;
      checks++; if (rsp_ready !== 1'b0) begin errors++; $display("FAIL flushq_cycle1 got %b exp 0", rsp_ready); end
      @(posedge clk); #1;
      flush = 1'b0;
      #3;
      checks++; if (rsp_ready !== 1'b1 || rsp_paddr !== 32'h0333_3004) begin errors++;
         $display("FAIL flushq_resp got ready %b pa %h exp 1 03333004", rsp_ready, rsp_paddr); end
      rsp_done = 1'b1;
      @(posedge clk); #1;
      rsp_done = 1'b0; req_valid = 1'b0;
      access(32'h0000_B008, 1'b0);
      checks++; if (lat !== 2 || pa !== 32'h0333_3008) begin errors++;
         $display("FAIL flushq_not_alloc got lat %0d pa %h exp 2 03333008", lat, pa); end
      set_tlb(32'h0666_6000, 1'b0, 1'b0, 1'b1);
      access(32'h0000_C000, 1'b0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      access(32'h0000_B00c, 1'b0);
      checks++; if (lat !== 2) begin errors++; $display("FAIL flushc_b got lat %0d exp 2", lat); end
      access(32'h0000_C00c, 1'b0);
      checks++; if (lat !== 2) begin errors++; $display("FAIL flushc_c got lat %0d exp 2", lat); end
   endtask

   task automatic test_back_to_back();
      set_tlb(32'h0777_7000, 1'b0, 1'b0, 1'b1);
      access(32'h0000_D010, 1'b0);
      access(32'h0000_C020, 1'b0);
      checks++; if (lat !== 0 || pa !== 32'h0666_6020) begin errors++;
         $display("FAIL b2b_hit_after_resp got lat %0d pa %h exp 0 06666020", lat, pa); end
      access(32'h0000_D030, 1'b0);
      checks++; if (lat !== 0 || pa !== 32'h0777_7030) begin errors++;
         $display("FAIL b2b_new_entry got lat %0d pa %h exp 0 07777030", lat, pa); end
   endtask

   task automatic test_cancel_reset();
      set_tlb(32'h0888_8000, 1'b0, 1'b0, 1'b1);
      req_valid = 1'b1; req_wr = 1'b0; req_vaddr = 32'h0000_E000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      #3;
      checks++; if (rsp_ready !== 1'b0 || rsp_paddr !== 32'h0) begin errors++;
         $display("FAIL cancel_resp got ready %b pa %h exp 0 0", rsp_ready, rsp_paddr); end
      @(posedge clk); #1;
      access(32'h0000_C040, 1'b0);
      checks++; if (lat !== 0 || pa !== 32'h0666_6040) begin errors++;
         $display("FAIL cancel_back_to_check got lat %0d pa %h exp 0 06666040", lat, pa); end
      set_tlb(32'h0999_9000, 1'b0, 1'b0, 1'b1);
      req_valid = 1'b1; req_vaddr = 32'h0000_F000;
      @(posedge clk); #1;
      resetn = 1'b0; req_valid = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      #3;
      checks++; if (rsp_ready !== 1'b0 || tlb_vaddr !== 32'h0) begin errors++;
         $display("FAIL rstq_outputs got ready %b tlb_vaddr %h exp 0 0", rsp_ready, tlb_vaddr); end
      @(posedge clk); #1;
      access(32'h0000_F004, 1'b0);
      checks++; if (lat !== 2 || pa !== 32'h0999_9004) begin errors++;
         $display("FAIL rstq_not_alloc got lat %0d pa %h exp 2 09999004", lat, pa); end
      access(32'h0000_C000, 1'b0);
      checks++; if (lat !== 2) begin errors++; $display("FAIL rstq_entries_cleared got lat %0d exp 2", lat); end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_miss_hit();
      test_replace();
      test_exceptions();
      test_flush();
      test_back_to_back();
      test_cancel_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
